tx_window_ctrl: RTL and testbench



---
 rtl/tx_window_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tx_window_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_window_ctrl.sv
// Transmit-window controller for the downlink path.
// Opens a tx window on a synchronised rising edge of start_req and closes it
// on abort, tick timeout or buffer drain, optionally followed by a cooldown
// during which new requests are ignored.
module tx_window_ctrl #(
  parameter int unsigned ADDR_W         = 19,
  parameter int unsigned CNT_W          = 14,
  parameter int unsigned TIMEOUT_TICKS  = 4800,
  parameter int unsigned COOLDOWN_TICKS = 0,
  parameter int unsigned DRAIN_MARGIN   = 1,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start_req,
  input  logic              abort,
  input  logic              retrig_en,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W-1:0] rd_ptr,
  output logic              tx_enable,
  output logic              busy,
  output logic [CNT_W-1:0]  elapsed,
  output logic [1:0]        stop_reason,
  output logic              done_pulse
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  localparam bit                HAS_CD    = (COOLDOWN_TICKS != 0);
  localparam int unsigned       CD_W      = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
  localparam logic [CD_W-1:0]   CD_LAST   = CD_W'(COOLDOWN_TICKS - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0]  TO_VAL    = CNT_W'(TIMEOUT_TICKS);
  localparam logic [ADDR_W-1:0] DRAIN_LIM = ADDR_W'(DRAIN_MARGIN);

  localparam logic [1:0] RSN_TIMEOUT = 2'b01;
  localparam logic [1:0] RSN_DRAINED = 2'b10;
  localparam logic [1:0] RSN_ABORT   = 2'b11;

  state_t            state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic              synced;
  logic              synced_d;
  logic              armed;
  logic              start_edge;
  logic              first_q;
  logic [CD_W-1:0]   cd_cnt;
  logic [ADDR_W-1:0] ptr_diff;
  logic              drained;
  logic              timeout_hit;
  logic              exit_now;
  logic [1:0]        exit_reason;

  // fill_q tracks which synchroniser stages hold a real sample since reset;
  // armed requires start_req to be seen low first, so a request held high
  // through reset release does not count as an edge.
  assign synced     = sync_q[SYNC_STAGES-1];
  assign start_edge = synced & ~synced_d & armed;

  // Synchroniser, edge register and arming of the start request
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      fill_q   <= '0;
      synced_d <= 1'b0;
      armed    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], start_req};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      synced_d <= synced;
      armed    <= armed | (fill_q[SYNC_STAGES-1] & ~synced);
    end
  end

  // Exit condition decode for the ACTIVE state, abort > timeout > drained
  always_comb begin
    ptr_diff    = wr_ptr - rd_ptr;
    drained     = (ptr_diff <= DRAIN_LIM);
    timeout_hit = (tick && (elapsed == TO_LAST)) || (elapsed >= TO_VAL);
    exit_now    = 1'b1;
    exit_reason = RSN_ABORT;
    if (abort) begin
      exit_reason = RSN_ABORT;
    end else if (timeout_hit) begin
      exit_reason = RSN_TIMEOUT;
    end else if (drained && !first_q) begin
      exit_reason = RSN_DRAINED;
    end else begin
      exit_now    = 1'b0;
      exit_reason = 2'b00;
    end
  end

  // Window FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      tx_enable   <= 1'b0;
      busy        <= 1'b0;
      elapsed     <= '0;
      stop_reason <= 2'b00;
      done_pulse  <= 1'b0;
      first_q     <= 1'b0;
      cd_cnt      <= '0;
    end else begin
      done_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state       <= ACTIVE;
            tx_enable   <= 1'b1;
            busy        <= 1'b1;
            elapsed     <= '0;
            stop_reason <= 2'b00;
            first_q     <= 1'b1;
          end
        end
        ACTIVE: begin
          first_q <= 1'b0;
          if (exit_now) begin
            tx_enable   <= 1'b0;
            done_pulse  <= 1'b1;
            stop_reason <= exit_reason;
            // The closing tick still counts, so a timeout ends at TIMEOUT_TICKS.
            if (tick && (elapsed != '1)) begin
              elapsed <= elapsed + 1'b1;
            end
            if (HAS_CD) begin
              state  <= COOLDOWN;
              cd_cnt <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (start_edge && retrig_en) begin
            elapsed <= '0;
          end else if (tick && (elapsed != '1)) begin
            elapsed <= elapsed + 1'b1;
          end
        end
        COOLDOWN: begin
          if (tick) begin
            if (cd_cnt == CD_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cd_cnt <= cd_cnt + 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          tx_enable <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_window_ctrl.sv
// Directed bench for tx_window_ctrl: a cycle-by-cycle vector table for the
// timeout and wrap-around drain windows, then short sequences for abort,
// retrigger, cooldown, reset and the drained-at-start case.
module tb_tx_window_ctrl;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start_req;
  logic       abort;
  logic       retrig_en;
  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;

  logic       a_tx, a_busy, a_done;
  logic [7:0] a_el;
  logic [1:0] a_rsn;
  logic       b_tx, b_busy, b_done;
  logic [7:0] b_el;
  logic [1:0] b_rsn;

  int unsigned total;
  int unsigned passed;

  // No cooldown
  tx_window_ctrl #(
    .ADDR_W(4), .CNT_W(8), .TIMEOUT_TICKS(5), .COOLDOWN_TICKS(0),
    .DRAIN_MARGIN(1), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .reset(reset), .tick(tick), .start_req(start_req),
    .abort(abort), .retrig_en(retrig_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .tx_enable(a_tx), .busy(a_busy), .elapsed(a_el),
    .stop_reason(a_rsn), .done_pulse(a_done)
  );

  // Two-tick cooldown
  tx_window_ctrl #(
    .ADDR_W(4), .CNT_W(8), .TIMEOUT_TICKS(5), .COOLDOWN_TICKS(2),
    .DRAIN_MARGIN(1), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .start_req(start_req),
    .abort(abort), .retrig_en(retrig_en), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
    .tx_enable(b_tx), .busy(b_busy), .elapsed(b_el),
    .stop_reason(b_rsn), .done_pulse(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       tk;
    logic       ab;
    logic       rt;
    logic [3:0] wr;
    logic [3:0] rd;
    logic       e_tx;
    logic       e_busy;
    logic [7:0] e_el;
    logic [1:0] e_rsn;
    logic       e_done;
  } vec_t;

  vec_t tv [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs change at negedge; outputs are checked at the following negedge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; start_req = 1'b0; tick = 1'b0; abort = 1'b0; retrig_en = 1'b0;
    wr_ptr = 4'd10; rd_ptr = 4'd0;
    cyc(); cyc();
    reset = 1'b1;
    repeat (4) cyc();
  endtask

  // Start pulse two clocks wide; window is open after the third edge.
  task automatic open_win();
    start_req = 1'b1; cyc(); cyc();
    start_req = 1'b0; cyc();
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;

    //          st tk ab rt wr  rd   tx bsy el rsn dn
    tv[0]  = '{1, 0, 0, 0, 10, 0,   0, 0, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 0, 10, 0,   0, 0, 0, 0, 0};
    tv[2]  = '{0, 0, 0, 0, 10, 0,   1, 1, 0, 0, 0};
    tv[3]  = '{0, 1, 0, 0, 10, 0,   1, 1, 1, 0, 0};
    tv[4]  = '{0, 0, 0, 0, 10, 0,   1, 1, 1, 0, 0};
    tv[5]  = '{0, 1, 0, 0, 10, 0,   1, 1, 2, 0, 0};
    tv[6]  = '{0, 1, 0, 0, 10, 0,   1, 1, 3, 0, 0};
    tv[7]  = '{0, 0, 0, 0, 10, 0,   1, 1, 3, 0, 0};
    tv[8]  = '{0, 1, 0, 0, 10, 0,   1, 1, 4, 0, 0};
    tv[9]  = '{0, 1, 0, 0, 10, 0,   0, 0, 5, 1, 1};
    tv[10] = '{0, 0, 0, 0, 10, 0,   0, 0, 5, 1, 0};
    tv[11] = '{0, 1, 0, 0, 10, 0,   0, 0, 5, 1, 0};
    tv[12] = '{1, 0, 0, 0, 2, 14,   0, 0, 5, 1, 0};
    tv[13] = '{1, 0, 0, 0, 2, 14,   0, 0, 5, 1, 0};
    tv[14] = '{0, 0, 0, 0, 2, 14,   1, 1, 0, 0, 0};
    tv[15] = '{0, 0, 0, 0, 2, 15,   1, 1, 0, 0, 0};
    tv[16] = '{0, 0, 0, 0, 2, 0,    1, 1, 0, 0, 0};
    tv[17] = '{0, 0, 0, 0, 2, 1,    0, 0, 0, 2, 1};
    tv[18] = '{0, 0, 0, 0, 2, 1,    0, 0, 0, 2, 0};

    reset = 1'b0; start_req = 1'b0; tick = 1'b0; abort = 1'b0; retrig_en = 1'b0;
    wr_ptr = 4'd10; rd_ptr = 4'd0;
    #3;
    chk("reset_tx",   a_tx,   0);
    chk("reset_busy", a_busy, 0);
    chk("reset_el",   a_el,   0);
    chk("reset_rsn",  a_rsn,  0);
    chk("reset_done", a_done, 0);

    // Timeout window, then wrap-around drain window
    do_reset();
    for (int i = 0; i < 19; i++) begin
      start_req = tv[i].start; tick = tv[i].tk; abort = tv[i].ab;
      retrig_en = tv[i].rt; wr_ptr = tv[i].wr; rd_ptr = tv[i].rd;
      cyc();
      chk($sformatf("vec%0d_tx", i),   a_tx,   tv[i].e_tx);
      chk($sformatf("vec%0d_busy", i), a_busy, tv[i].e_busy);
      chk($sformatf("vec%0d_el", i),   a_el,   tv[i].e_el);
      chk($sformatf("vec%0d_rsn", i),  a_rsn,  tv[i].e_rsn);
      chk($sformatf("vec%0d_done", i), a_done, tv[i].e_done);
    end
    tick = 1'b0;

    // Abort together with the 5th tick
    do_reset();
    open_win();
    ticks(4);
    chk("abt_el4", a_el, 4);
    tick = 1'b1; abort = 1'b1; cyc();
    tick = 1'b0; abort = 1'b0;
    chk("abt_tx",   a_tx,   0);
    chk("abt_rsn",  a_rsn,  3);
    chk("abt_done", a_done, 1);
    cyc();
    chk("abt_done_once", a_done, 0);
    chk("abt_rsn_hold",  a_rsn,  3);

    // Retrigger enabled: restart at elapsed 3, close 5 ticks later
    do_reset();
    open_win();
    ticks(3);
    retrig_en = 1'b1;
    open_win();
    chk("rt1_el0", a_el, 0);
    chk("rt1_tx",  a_tx, 1);
    ticks(4);
    chk("rt1_tx_after4", a_tx, 1);
    chk("rt1_el4",       a_el, 4);
    ticks(1);
    chk("rt1_tx_close", a_tx,  0);
    chk("rt1_rsn",      a_rsn, 1);
    chk("rt1_el5",      a_el,  5);

    // Retrigger disabled: same stimulus closes at the original 5th tick
    do_reset();
    open_win();
    ticks(3);
    retrig_en = 1'b0;
    open_win();
    chk("rt0_el3", a_el, 3);
    ticks(1);
    chk("rt0_tx_after4", a_tx, 1);
    ticks(1);
    chk("rt0_tx_close", a_tx,  0);
    chk("rt0_rsn",      a_rsn, 1);
    chk("rt0_done",     a_done, 0);

    // Cooldown of 2 ticks on dut_b
    do_reset();
    open_win();
    ticks(5);
    chk("cd_tx_closed", b_tx,   0);
    chk("cd_busy",      b_busy, 1);
    chk("cd_rsn",       b_rsn,  1);
    ticks(1);
    open_win();
    chk("cd_ign_tx",   b_tx,   0);
    chk("cd_ign_busy", b_busy, 1);
    ticks(1);
    chk("cd_idle_busy", b_busy, 0);
    chk("cd_idle_tx",   b_tx,   0);
    open_win();
    chk("cd_new_tx",  b_tx,  1);
    chk("cd_new_rsn", b_rsn, 0);
    chk("cd_new_el",  b_el,  0);

    // Asynchronous reset mid-window
    do_reset();
    open_win();
    ticks(3);
    chk("rst_el3", a_el, 3);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_tx",   a_tx,   0);
    chk("rst_async_busy", a_busy, 0);
    chk("rst_async_el",   a_el,   0);
    chk("rst_async_rsn",  a_rsn,  0);
    chk("rst_async_done", a_done, 0);
    start_req = 1'b1;
    @(negedge clk);
    cyc();
    reset = 1'b1;
    repeat (6) cyc();
    chk("rst_held_tx", a_tx, 0);
    start_req = 1'b0;
    repeat (3) cyc();
    open_win();
    chk("rst_reedge_tx", a_tx, 1);

    // Buffer already drained when the window opens: 2-clk window
    do_reset();
    wr_ptr = 4'd5; rd_ptr = 4'd5;
    open_win();
    chk("drn0_tx_c1", a_tx, 1);
    cyc();
    chk("drn0_tx_c2", a_tx, 1);
    cyc();
    chk("drn0_tx_close", a_tx,   0);
    chk("drn0_rsn",      a_rsn,  2);
    chk("drn0_done",     a_done, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
